vedic_mult_pipe: RTL and testbench
==================================

VEDIC_MULT_PIPE -- requirements
Module: vedic_mult_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand width; legal values 4, 8, 16, 32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on a, b is valid.
REQ-005 in_ready  output  1  block accepts a pair this cycle.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 sign_mode  input  1  1 = two's-complement operands; present only with VEDIC_SIGNED_EN.
REQ-009 out_valid  output  1  product p is valid.
REQ-010 out_ready  input  1  downstream accepts p this cycle.
REQ-011 p  output  2*WIDTH  product.
REQ-012 busy  output  1  high while any pipeline stage holds a valid entry.

Function
REQ-013 Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-014 Three registered stages: S1 captures a, b (and sign info); S2 holds the four WIDTH/2 x WIDTH/2 quadrant products (aL*bL, aL*bH, aH*bL, aH*bH) in Vedic urdhva-tiryak decomposition; S3 holds p.
REQ-015 S2 quadrant products shall be formed by recursive Vedic decomposition down to 2x2 cells; no `*` operator.
REQ-016 S3 product = aH*bH<<WIDTH + (aL*bH + aH*bL)<<(WIDTH/2) + aL*bL, computed at exactly 2*WIDTH bits with no truncation; the cross-term sum carry (bit WIDTH) is retained.
REQ-017 Latency: exactly 3 cycles from the in transfer to out_valid high when out_ready stays high.
REQ-018 Throughput: one operand pair per cycle with no bubbles while out_ready is high.
REQ-019 Stage k advances when stage k+1 is empty or advancing in the same cycle; in_ready = !S1_valid | S1 advancing (combinational, no registered skid).
REQ-020 With out_ready low and all three stages full, in_ready shall be 0 and all stage contents shall hold unchanged.
REQ-021 p and out_valid shall remain stable while out_valid=1 and out_ready=0.
REQ-022 in_valid asserted while in_ready=0 shall not load operands; a, b may change freely without effect.
REQ-023 Simultaneous in and out transfer with a full pipe shall shift every stage with no loss or duplication.
REQ-024 Pipeline order is strictly FIFO; results emerge in input order.
REQ-025 busy = S1_valid | S2_valid | S3_valid.

Reset
REQ-026 rst_n low shall immediately clear all stage valid bits; out_valid=0, busy=0, p=0, in_ready=1.
REQ-027 Reset asserted mid-operation shall discard all in-flight products; none shall appear after release.
REQ-028 The first in transfer may occur on the first rising edge after rst_n deasserts.

Configuration
REQ-029 Macro VEDIC_SIGNED_EN defined: port sign_mode exists and is sampled with a, b at the in transfer and carried through the pipeline with the data.
REQ-030 With VEDIC_SIGNED_EN and sign_mode=1: operands are converted to magnitude in S1, multiplied unsigned, and p is negated in S3 when the operand signs differ; -2^(WIDTH-1) shall be handled correctly.
REQ-031 With VEDIC_SIGNED_EN and sign_mode=0, or with the macro undefined: unsigned multiplication; when undefined, sign_mode is absent and no sign logic is synthesised.

Verification (WIDTH=8)
REQ-032 a=13, b=11, out_ready=1 -> p=143 (0x008F) with out_valid exactly 3 cycles after the in transfer.
REQ-033 a=255, b=255 -> p=0xFE01; a=0, b=200 -> p=0; back-to-back every cycle -> one result per cycle, in order.
REQ-034 Hold out_ready=0, issue 4 pairs -> 3 accepted, in_ready=0 on the 4th, p held; release -> 3 correct results, then 4th accepted.
REQ-035 Pulse rst_n low with 2 pairs in flight -> out_valid=0, busy=0 immediately, no stale product after release.
REQ-036 VEDIC_SIGNED_EN, sign_mode=1: a=-3 (0xFD), b=5 -> p=0xFFF1; a=-128, b=-128 -> p=0x4000; sign_mode=0, a=0xFD, b=5 -> p=0x04F1.
REQ-037 Random 10k pairs with random out_ready stalls, unsigned and signed, checked against a reference model, zero mismatches.

Source files
------------

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage pipelined WIDTH x WIDTH multiplier built from Vedic (urdhva-tiryak) 2x2 cells.
// Latency 3 cycles from input transfer to out_valid, one pair per cycle; in_ready = !S1 valid | S1 advancing.
// Backpressure: out_ready low stalls S3, then S2, S1 and in_ready combinationally; full pipe holds unchanged.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/p product handshake; busy = any stage holds a valid entry.
// Option: define VEDIC_SIGNED_EN to add sign_mode (1 = two's-complement operands); default build is unsigned only.
module vedic_mult_pipe #(
   parameter int WIDTH = 8  // 4, 8, 16 or 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef VEDIC_SIGNED_EN
   input  logic               sign_mode,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);
   localparam int H  = WIDTH / 2;
   // Tree level whose blocks are H bits wide, i.e. the four quadrant products.
   localparam int NL = $clog2(WIDTH) - 1;

   logic               r_s1_vld, r_s2_vld, r_s3_vld;
   logic [WIDTH-1:0]   r_s1_a, r_s1_b;
   logic [WIDTH-1:0]   r_s2_ll, r_s2_lh, r_s2_hl, r_s2_hh;
   logic [2*WIDTH-1:0] r_s3_p;

   logic               w_s1_en, w_s2_en, w_s3_en;
   logic [WIDTH-1:0]   w_a_mag, w_b_mag;
   logic [WIDTH-1:0]   w_ll, w_lh, w_hl, w_hh;
   logic [WIDTH:0]     w_cross;
   logic [2*WIDTH-1:0] w_sum, w_prod;

   // A stage may load when it is empty or its content leaves this cycle.
   assign w_s3_en   = !r_s3_vld || out_ready;
   assign w_s2_en   = !r_s2_vld || w_s3_en;
   assign w_s1_en   = !r_s1_vld || w_s2_en;
   assign in_ready  = w_s1_en;
   assign out_valid = r_s3_vld;
   assign p         = r_s3_p;
   assign busy      = r_s1_vld || r_s2_vld || r_s3_vld;

`ifdef VEDIC_SIGNED_EN
   logic w_a_neg, w_b_neg;
   logic r_s1_neg, r_s2_neg;

   assign w_a_neg = sign_mode & a[WIDTH-1];
   assign w_b_neg = sign_mode & b[WIDTH-1];
   // -2^(WIDTH-1) negates to itself, which read as unsigned is exactly its magnitude.
   assign w_a_mag = w_a_neg ? ({WIDTH{1'b0}} - a) : a;
   assign w_b_mag = w_b_neg ? ({WIDTH{1'b0}} - b) : b;
   assign w_prod  = r_s2_neg ? ({(2*WIDTH){1'b0}} - w_sum) : w_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_neg <= 1'b0;
         r_s2_neg <= 1'b0;
      end else begin
         if (w_s1_en && in_valid) r_s1_neg <= w_a_neg ^ w_b_neg;
         if (w_s2_en && r_s1_vld) r_s2_neg <= r_s1_neg;
      end
   end
`else
   assign w_a_mag = a;
   assign w_b_mag = b;
   assign w_prod  = w_sum;
`endif

   // Vedic decomposition, built bottom-up: level l holds every (a block i) x (b block j) product of
   // 2^l-bit blocks; level 1 is 2x2 cells, each higher level joins four products of the level below.
   for (genvar l = 1; l <= NL; l++) begin : g_lv
      localparam int S  = 2 ** l;
      localparam int NB = WIDTH / S;
      logic [NB*NB*2*S-1:0] w_lvl;
      for (genvar i = 0; i < NB; i++) begin : g_i
         for (genvar j = 0; j < NB; j++) begin : g_j
            localparam int E = (i*NB + j) * 2 * S;
            if (l == 1) begin : g_cell
               logic [1:0] w_x, w_y;
               logic       w_t0, w_t1a, w_t1b, w_t2, w_c;
               assign w_x   = r_s1_a[2*i +: 2];
               assign w_y   = r_s1_b[2*j +: 2];
               assign w_t0  = w_x[0] & w_y[0];
               assign w_t1a = w_x[1] & w_y[0];
               assign w_t1b = w_x[0] & w_y[1];
               assign w_t2  = w_x[1] & w_y[1];
               assign w_c   = w_t1a & w_t1b;
               assign w_lvl[E +: 4] = {w_t2 & w_c, w_t2 ^ w_c, w_t1a ^ w_t1b, w_t0};
            end else begin : g_join
               localparam int HS = S / 2;
               localparam int PN = 2 * NB;
               logic [S-1:0] w_pll, w_plh, w_phl, w_phh;
               logic [S:0]   w_x;
               assign w_pll = g_lv[l-1].w_lvl[((2*i)*PN + 2*j)*S +: S];
               assign w_plh = g_lv[l-1].w_lvl[((2*i)*PN + 2*j + 1)*S +: S];
               assign w_phl = g_lv[l-1].w_lvl[((2*i + 1)*PN + 2*j)*S +: S];
               assign w_phh = g_lv[l-1].w_lvl[((2*i + 1)*PN + 2*j + 1)*S +: S];
               // Cross sum keeps its carry bit before being shifted into place.
               assign w_x   = {1'b0, w_plh} + {1'b0, w_phl};
               assign w_lvl[E +: 2*S] = {w_phh, w_pll} + {{(HS-1){1'b0}}, w_x, {HS{1'b0}}};
            end
         end
      end
   end

   // Top level of the tree has a 2x2 block grid: (0,0)=aL*bL, (0,1)=aL*bH, (1,0)=aH*bL, (1,1)=aH*bH.
   assign w_ll = g_lv[NL].w_lvl[0       +: WIDTH];
   assign w_lh = g_lv[NL].w_lvl[WIDTH   +: WIDTH];
   assign w_hl = g_lv[NL].w_lvl[2*WIDTH +: WIDTH];
   assign w_hh = g_lv[NL].w_lvl[3*WIDTH +: WIDTH];

   assign w_cross = {1'b0, r_s2_lh} + {1'b0, r_s2_hl};
   assign w_sum   = {r_s2_hh, r_s2_ll} + {{(H-1){1'b0}}, w_cross, {H{1'b0}}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_vld <= 1'b0;
         r_s2_vld <= 1'b0;
         r_s3_vld <= 1'b0;
         r_s1_a   <= '0;
         r_s1_b   <= '0;
         r_s2_ll  <= '0;
         r_s2_lh  <= '0;
         r_s2_hl  <= '0;
         r_s2_hh  <= '0;
         r_s3_p   <= '0;
      end else begin
         if (w_s1_en) r_s1_vld <= in_valid;
         if (w_s1_en && in_valid) begin
            r_s1_a <= w_a_mag;
            r_s1_b <= w_b_mag;
         end
         if (w_s2_en) r_s2_vld <= r_s1_vld;
         if (w_s2_en && r_s1_vld) begin
            r_s2_ll <= w_ll;
            r_s2_lh <= w_lh;
            r_s2_hl <= w_hl;
            r_s2_hh <= w_hh;
         end
         if (w_s3_en) r_s3_vld <= r_s2_vld;
         if (w_s3_en && r_s2_vld) r_s3_p <= w_prod;
      end
   end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
module tb_vedic_mult_pipe;
   localparam int W = 8;
`ifdef VEDIC_SIGNED_EN
   localparam bit SIGNED_BUILD = 1'b1;
`else
   localparam bit SIGNED_BUILD = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n;
   logic           in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]   a, b;
   logic [2*W-1:0] p;
   logic           sign_mode;

   int             n_cmp = 0;
   int             n_err = 0;
   logic [2*W-1:0] exp_q[$];

   always #5 clk = ~clk;

   vedic_mult_pipe #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
`ifdef VEDIC_SIGNED_EN
      .sign_mode (sign_mode),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .p         (p),
      .busy      (busy)
   );

   // Reference: plain integer multiplication on the operands as the mode interprets them.
   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm);
      longint sx, sy, pr;
      if (sm && SIGNED_BUILD) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'(x);
         sy = longint'(y);
      end
      pr = sx * sy;
      return pr[2*W-1:0];
   endfunction

   function automatic logic [W-1:0] rnd_op();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1:       v = '1;
         2:       v = {1'b1, {(W-1){1'b0}}};
         3:       v = {1'b0, {(W-1){1'b1}}};
         default: v = W'($urandom);
      endcase
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Scoreboard monitor: pushes the model's answer on every input transfer, pops on every output transfer.
   task automatic monitor();
      logic           hold = 1'b0;
      logic [2*W-1:0] p_hold = '0;
      logic [2*W-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               check("stall_out_valid", 64'(out_valid), 64'd1);
               check("stall_p_stable", 64'(p), 64'(p_hold));
            end
            hold   = out_valid && !out_ready;
            p_hold = p;
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_output: got p=%0h, required no output (t=%0t)", p, $time);
               end else begin
                  e = exp_q.pop_front();
                  check("scoreboard_p", 64'(p), 64'(e));
               end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_mul(a, b, sign_mode));
         end
      end
   endtask

   // Starts and ends just after a rising edge; returns how many cycles in_ready held the pair off.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm, output int waits);
      a = x; b = y; sign_mode = sm; in_valid = 1'b1;
      waits = 0;
      @(negedge clk);
      while (!in_ready && waits < 100) begin
         @(posedge clk); #1;
         waits++;
         @(negedge clk);
      end
      if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Single pair through an empty pipe with out_ready high: checks acceptance, latency and value.
   task automatic run_one(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                          input logic [2*W-1:0] req, input string nm);
      int w, lat;
      out_ready = 1'b1;
      send(x, y, sm, w);
      check({nm, "_accept_wait"}, 64'(w), 64'd0);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      check({nm, "_latency"}, 64'(lat), 64'd3);
      check({nm, "_p"}, 64'(p), 64'(req));
      @(posedge clk); #1;
   endtask

   task automatic drain(input string nm);
      int cnt;
      in_valid = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while (busy && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check({nm, "_drain_busy"}, 64'(busy), 64'd0);
      check({nm, "_drain_queue"}, 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      int w, tot, cnt, sent, cyc;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sign_mode = 1'b0; out_ready = 1'b1;
      fork
         monitor();
      join_none

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_p", 64'(p), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Release, then the first pair goes in on the very next rising edge.
      rst_n = 1'b1;
      run_one(8'd13, 8'd11, 1'b0, 16'h008F, "d13x11");
      run_one(8'd255, 8'd255, 1'b0, 16'hFE01, "d255x255");
      run_one(8'd0, 8'd200, 1'b0, 16'h0000, "d0x200");
`ifdef VEDIC_SIGNED_EN
      run_one(8'hFD, 8'd5, 1'b1, 16'hFFF1, "sm3x5");
      run_one(8'h80, 8'h80, 1'b1, 16'h4000, "smin_sq");
      run_one(8'hFD, 8'd5, 1'b0, 16'h04F1, "u253x5");
`endif

      // Back-to-back stream: no input bubbles, results checked in order by the monitor.
      tot = 0;
      for (int k = 0; k < 8; k++) begin
         send(rnd_op(), rnd_op(), 1'(SIGNED_BUILD ? $urandom_range(0, 1) : 0), w);
         tot += w;
      end
      check("b2b_no_bubble", 64'(tot), 64'd0);
      drain("b2b");

      // Stalled output: three pairs fill the pipe, the fourth is held off and p stays put.
      out_ready = 1'b0;
      tot = 0;
      send(8'd255, 8'd255, 1'b0, w); tot += w;
      send(8'd17, 8'd3, 1'b0, w);    tot += w;
      send(8'd100, 8'd2, 1'b0, w);   tot += w;
      check("bp_three_accepted", 64'(tot), 64'd0);
      a = 8'd7; b = 8'd9; sign_mode = 1'b0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("bp_in_ready_low", 64'(in_ready), 64'd0);
         check("bp_p_held", 64'(p), 64'hFE01);
         @(posedge clk); #1;
         a = rnd_op(); b = rnd_op();  // ignored while stalled
      end
      a = 8'd7; b = 8'd9;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_accept", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      drain("bp");

      // Reset with two pairs in flight: everything is dropped at once and nothing stale appears.
      send(8'd21, 8'd4, 1'b0, w);
      send(8'd33, 8'd5, 1'b0, w);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_p", 64'(p), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd1);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) cnt++;
      end
      check("no_stale_output", 64'(cnt), 64'd0);
      @(posedge clk); #1;

      // Random traffic with random output stalls; operands change freely while not accepted.
      sent = 0;
      cyc = 0;
      while (sent < 10000 && cyc < 60000) begin
         a = rnd_op();
         b = rnd_op();
         sign_mode = 1'(SIGNED_BUILD ? $urandom_range(0, 1) : 0);
         in_valid = ($urandom_range(0, 9) < 8);
         out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (in_valid && in_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      check("random_sent", 64'(sent), 64'd10000);
      drain("random");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
